mshr_miss_ctrl: RTL and testbench
=================================

Name: mshr_miss_ctrl

Overview:
Sequences the MSHR for the M-stage data cache.
- Accepts cache-miss requests and decides per request: merge into an existing MSHR entry, allocate a new entry, or stall when full.
- Issues allocated misses to the memory bus and deallocates the MSHR head when an in-order fill returns.
- One cycle after each fill, presents the head entry's queue slots and wake vector to the wakeup logic.

Parameters:
PADDR_W, 15, physical line address width
QSLOT_W, 8, queue-entry slot bitvector width
TCID_W, 7, transaction/cache id width
DEPTH, 8, MSHR entry count; counters are clog2(DEPTH)+1 bits

Ports:
clk  in  1  clock
clr  in  1  synchronous, active-high reset
miss_valid  in  1  cache miss request present
miss_paddr  in  PADDR_W  miss line address (also drives MSHR pAddress)
miss_ptcid  in  TCID_W  id forwarded to bus request
miss_ready  out  1  miss accepted this cycle
mshr_hit  in  1  MSHR match on miss_paddr (combinational)
mshr_full  in  1  MSHR full
mshr_alloc  out  1  MSHR write strobe
mshr_dealloc  out  1  MSHR head pop strobe
mshr_qslots  in  QSLOT_W  MSHR head queue slots
mshr_wake  in  2  MSHR head wake vector
bus_req_valid  out  1  memory read request valid
bus_req_paddr  out  PADDR_W  request address
bus_req_ptcid  out  TCID_W  request id
bus_req_ready  in  1  bus accepts request
fill_valid  in  1  memory fill returned (in issue order)
fill_ready  out  1  fill accepted
wake_valid  out  1  wake pulse
wake_qslots  out  QSLOT_W  slots to wake
wake_vector  out  2  {rd,sw} wake vector
outstanding  out  4  allocated MSHR entries (0..DEPTH)
err  out  1  sticky protocol error

Behaviour:
- Reset (clr at posedge): state=IDLE; outstanding=0; issued=0; err=0; wake_valid=0; bus_req_valid=0; wake_qslots/wake_vector/bus_req_paddr/bus_req_ptcid=0. A reset mid-request drops the pending bus request.
- FSM states:
  - IDLE: misses are accepted.
  - REQ: holds bus_req_valid with stable paddr/ptcid until bus_req_ready, then returns to IDLE. REQ->IDLE takes the handshake cycle; no miss is accepted in that cycle.
- fill_take = fill_valid & (issued != 0).
  - fill_ready = (issued != 0).
  - Fills are taken in both IDLE and REQ.
- Fills have priority over misses. miss_ready = (state==IDLE) & ~fill_take & (mshr_hit | ~mshr_full).
- Accepted miss with mshr_hit=1 (merge):
  - no mshr_alloc, no bus request, no counter change.
  - The MSHR merges the slot internally.
- Accepted miss with mshr_hit=0 (allocate):
  - mshr_alloc=1 the same cycle.
  - bus_req_paddr/ptcid are registered from the miss.
  - state->REQ; bus_req_valid=1 from the next cycle.
- Miss with mshr_hit=0 & mshr_full=1: miss_ready=0, stall, no strobes.
- mshr_alloc and mshr_dealloc are never high in the same cycle; this follows from fill priority.
- fill_take cycle:
  - mshr_dealloc=1 (combinational).
  - mshr_qslots/mshr_wake are captured.
  - Next cycle: wake_valid=1 for exactly one cycle with the captured values.
- Back-to-back fills give wake_valid on consecutive cycles.
- Counters:
  - outstanding +1 on alloc, -1 on dealloc.
  - issued +1 on bus handshake (bus_req_valid & bus_req_ready), -1 on fill_take.
  - issued <= outstanding always.
- fill_valid while issued==0: fill ignored (fill_ready=0), err set sticky until clr.
- outstanding never exceeds DEPTH. Alloc is gated by ~mshr_full; an alloc at outstanding==DEPTH sets err.
- Output timing: all outputs are registered except miss_ready, mshr_alloc, mshr_dealloc and fill_ready.

Test Plan:
- Reset then single miss paddr=0x1A2B, hit=0, full=0:
  - cycle0: miss_ready=1, mshr_alloc=1.
  - cycle1: bus_req_valid=1, paddr=0x1A2B.
  - bus_req_ready at cycle3 -> IDLE at cycle4; outstanding=1, issued=1.
- fill_valid with mshr_qslots=0x05, mshr_wake=2'b10:
  - mshr_dealloc=1 the same cycle.
  - next cycle: wake_valid=1, wake_qslots=0x05, wake_vector=2'b10.
  - outstanding=0.
- Miss with mshr_hit=1: miss_ready=1, mshr_alloc=0, bus_req_valid stays 0, outstanding unchanged.
- mshr_full=1, hit=0, miss_valid held 4 cycles: miss_ready=0 throughout. Drop full: accepted that cycle with alloc=1.
- Simultaneous fill_valid and miss_valid in IDLE with issued=1: dealloc=1, miss_ready=0, alloc=0. Miss accepted the following cycle.
- fill_valid with issued=0: fill_ready=0, err=1 next cycle, stays 1. clr mid-REQ: bus_req_valid=0 and counters 0 the next cycle.

Source files
------------

// File: rtl/mshr_miss_ctrl_if.sv
// Signal bundle between the D-cache miss controller, its MSHR array, the memory bus and wakeup.
// master: controller side; slave: environment side (MSHR, bus, fill path, wakeup).
interface mshr_miss_ctrl_if #(
    parameter int unsigned PADDR_W = 15,
    parameter int unsigned QSLOT_W = 8,
    parameter int unsigned TCID_W  = 7,
    parameter int unsigned DEPTH   = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               miss_valid;
    logic [PADDR_W-1:0] miss_paddr;
    logic [TCID_W-1:0]  miss_ptcid;
    logic               miss_ready;

    logic               mshr_hit;
    logic               mshr_full;
    logic               mshr_alloc;
    logic               mshr_dealloc;
    logic [QSLOT_W-1:0] mshr_qslots;
    logic [1:0]         mshr_wake;

    logic               bus_req_valid;
    logic [PADDR_W-1:0] bus_req_paddr;
    logic [TCID_W-1:0]  bus_req_ptcid;
    logic               bus_req_ready;

    logic               fill_valid;
    logic               fill_ready;

    logic               wake_valid;
    logic [QSLOT_W-1:0] wake_qslots;
    logic [1:0]         wake_vector;

    logic [CNT_W-1:0]   outstanding;
    logic               err;

    modport master (
        input  miss_valid, miss_paddr, miss_ptcid,
        output miss_ready,
        input  mshr_hit, mshr_full, mshr_qslots, mshr_wake,
        output mshr_alloc, mshr_dealloc,
        output bus_req_valid, bus_req_paddr, bus_req_ptcid,
        input  bus_req_ready,
        input  fill_valid,
        output fill_ready,
        output wake_valid, wake_qslots, wake_vector,
        output outstanding, err
    );

    modport slave (
        output miss_valid, miss_paddr, miss_ptcid,
        input  miss_ready,
        output mshr_hit, mshr_full, mshr_qslots, mshr_wake,
        input  mshr_alloc, mshr_dealloc,
        input  bus_req_valid, bus_req_paddr, bus_req_ptcid,
        output bus_req_ready,
        output fill_valid,
        input  fill_ready,
        input  wake_valid, wake_qslots, wake_vector,
        input  outstanding, err
    );
endinterface

// File: rtl/mshr_miss_ctrl.sv
// MSHR sequencer for the M-stage data cache: merge/allocate/stall misses, issue bus reads,
// pop the MSHR head on in-order fills and pulse the head's wake info one cycle later.
module mshr_miss_ctrl #(
    parameter int unsigned PADDR_W = 15,
    parameter int unsigned QSLOT_W = 8,
    parameter int unsigned TCID_W  = 7,
    parameter int unsigned DEPTH   = 8
) (
    input logic             clk,
    input logic             clr,
    mshr_miss_ctrl_if.master mif
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic               err_q, err_d;
    logic               wake_valid_q, wake_valid_d;
    logic [QSLOT_W-1:0] wake_qslots_q, wake_qslots_d;
    logic [1:0]         wake_vector_q, wake_vector_d;
    logic               req_valid_q, req_valid_d;
    logic [PADDR_W-1:0] req_paddr_q, req_paddr_d;
    logic [TCID_W-1:0]  req_ptcid_q, req_ptcid_d;

    logic fill_ready, fill_take, miss_ready, alloc, bus_hs, at_max;

    // Fills win over misses, which is what keeps alloc and dealloc mutually exclusive.
    assign fill_ready = (issued_q != '0);
    assign fill_take  = mif.fill_valid & fill_ready;
    assign miss_ready = (state_q == StIdle) & ~fill_take & (mif.mshr_hit | ~mif.mshr_full);
    assign alloc      = mif.miss_valid & miss_ready & ~mif.mshr_hit;
    assign bus_hs     = req_valid_q & mif.bus_req_ready;
    assign at_max     = (outstanding_q == CNT_W'(DEPTH));

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_paddr_d = req_paddr_q;
        req_ptcid_d = req_ptcid_q;
        unique case (state_q)
            StIdle: begin
                if (alloc) begin
                    state_d     = StReq;
                    req_valid_d = 1'b1;
                    req_paddr_d = mif.miss_paddr;
                    req_ptcid_d = mif.miss_ptcid;
                end
            end
            StReq: begin
                if (bus_hs) begin
                    state_d     = StIdle;
                    req_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        // Saturate at DEPTH; an alloc past that is flagged instead of wrapping.
        if (alloc && !at_max) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (fill_take) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
        issued_d      = issued_q + CNT_W'(bus_hs) - CNT_W'(fill_take);
        err_d         = err_q | (mif.fill_valid & ~fill_ready) | (alloc & at_max);
        wake_valid_d  = fill_take;
        wake_qslots_d = fill_take ? mif.mshr_qslots : wake_qslots_q;
        wake_vector_d = fill_take ? mif.mshr_wake : wake_vector_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= StIdle;
            outstanding_q <= '0;
            issued_q      <= '0;
            err_q         <= 1'b0;
            wake_valid_q  <= 1'b0;
            wake_qslots_q <= '0;
            wake_vector_q <= '0;
            req_valid_q   <= 1'b0;
            req_paddr_q   <= '0;
            req_ptcid_q   <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            issued_q      <= issued_d;
            err_q         <= err_d;
            wake_valid_q  <= wake_valid_d;
            wake_qslots_q <= wake_qslots_d;
            wake_vector_q <= wake_vector_d;
            req_valid_q   <= req_valid_d;
            req_paddr_q   <= req_paddr_d;
            req_ptcid_q   <= req_ptcid_d;
        end
    end

    assign mif.miss_ready    = miss_ready;
    assign mif.mshr_alloc    = alloc;
    assign mif.mshr_dealloc  = fill_take;
    assign mif.fill_ready    = fill_ready;
    assign mif.bus_req_valid = req_valid_q;
    assign mif.bus_req_paddr = req_paddr_q;
    assign mif.bus_req_ptcid = req_ptcid_q;
    assign mif.wake_valid    = wake_valid_q;
    assign mif.wake_qslots   = wake_qslots_q;
    assign mif.wake_vector   = wake_vector_q;
    assign mif.outstanding   = outstanding_q;
    assign mif.err           = err_q;
endmodule

// File: tb/tb_mshr_miss_ctrl.sv
// Directed bench for mshr_miss_ctrl: a small behavioural model plus scoreboard queues for bus
// requests and wake pulses, checked with immediate assertions every cycle.
module tb_mshr_miss_ctrl;
    localparam int unsigned PADDR_W = 15;
    localparam int unsigned QSLOT_W = 8;
    localparam int unsigned TCID_W  = 7;
    localparam int unsigned DEPTH   = 8;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    mshr_miss_ctrl_if #(.PADDR_W(PADDR_W), .QSLOT_W(QSLOT_W), .TCID_W(TCID_W), .DEPTH(DEPTH)) mif ();

    mshr_miss_ctrl #(.PADDR_W(PADDR_W), .QSLOT_W(QSLOT_W), .TCID_W(TCID_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .mif (mif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [PADDR_W+TCID_W-1:0] bus_q[$];
    logic [QSLOT_W+1:0]        wake_q[$];

    bit m_req, m_err, m_wv;
    int m_out, m_iss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs against the model, advance, check registered ones.
    task automatic cycle();
        bit fr, ft, mr, al, hs;
        logic [PADDR_W+TCID_W-1:0] eb;
        logic [QSLOT_W+1:0]        ew;
        #1;
        fr = (m_iss != 0);
        ft = mif.fill_valid && fr;
        mr = !m_req && !ft && (mif.mshr_hit || !mif.mshr_full);
        al = mif.miss_valid && mr && !mif.mshr_hit;
        hs = m_req && mif.bus_req_ready;
        chk("miss_ready", mif.miss_ready, mr);
        chk("mshr_alloc", mif.mshr_alloc, al);
        chk("mshr_dealloc", mif.mshr_dealloc, ft);
        chk("fill_ready", mif.fill_ready, fr);
        if (hs) begin
            eb = bus_q.pop_front();
            chk("bus_req", {mif.bus_req_paddr, mif.bus_req_ptcid}, eb);
        end
        if (al) bus_q.push_back({mif.miss_paddr, mif.miss_ptcid});
        if (ft) wake_q.push_back({mif.mshr_qslots, mif.mshr_wake});
        if (clr) begin
            m_req = 0; m_err = 0; m_wv = 0; m_out = 0; m_iss = 0;
            bus_q.delete();
            wake_q.delete();
        end else begin
            if (al) begin
                if (m_out == DEPTH) m_err = 1;
                else m_out++;
                m_req = 1;
            end
            if (hs) begin
                m_req = 0;
                m_iss++;
            end
            if (ft) begin
                m_out--;
                m_iss--;
            end
            if (mif.fill_valid && !fr) m_err = 1;
            m_wv = ft;
        end
        @(posedge clk);
        #1;
        chk("bus_req_valid", mif.bus_req_valid, m_req);
        chk("outstanding", mif.outstanding, m_out);
        chk("err", mif.err, m_err);
        chk("wake_valid", mif.wake_valid, m_wv);
        if (m_wv) begin
            ew = wake_q.pop_front();
            chk("wake_data", {mif.wake_qslots, mif.wake_vector}, ew);
        end
    endtask

    initial begin
        clr = 1'b1;
        mif.miss_valid = 0; mif.miss_paddr = '0; mif.miss_ptcid = '0;
        mif.mshr_hit = 0; mif.mshr_full = 0; mif.mshr_qslots = '0; mif.mshr_wake = '0;
        mif.bus_req_ready = 0; mif.fill_valid = 0;
        m_req = 0; m_err = 0; m_wv = 0; m_out = 0; m_iss = 0;
        @(posedge clk);
        #1;
        cycle();
        clr = 1'b0;
        chk("rst_paddr", mif.bus_req_paddr, 0);
        chk("rst_ptcid", mif.bus_req_ptcid, 0);
        chk("rst_qslots", mif.wake_qslots, 0);
        chk("rst_vector", mif.wake_vector, 0);

        // Single allocating miss, handshake on the third REQ cycle.
        mif.miss_valid = 1; mif.miss_paddr = 15'h1A2B; mif.miss_ptcid = 7'h11;
        cycle();
        mif.miss_valid = 0;
        chk("t1_paddr", mif.bus_req_paddr, 15'h1A2B);
        cycle();
        cycle();
        mif.bus_req_ready = 1;
        cycle();
        mif.bus_req_ready = 0;
        chk("t1_outstanding", mif.outstanding, 1);
        chk("t1_issued", mif.fill_ready, 1);

        // In-order fill pops the head and wakes one cycle later.
        mif.fill_valid = 1; mif.mshr_qslots = 8'h05; mif.mshr_wake = 2'b10;
        cycle();
        mif.fill_valid = 0;
        chk("t2_qslots", mif.wake_qslots, 8'h05);
        chk("t2_vector", mif.wake_vector, 2'b10);
        chk("t2_outstanding", mif.outstanding, 0);
        cycle();

        // Merge into an existing entry.
        mif.miss_valid = 1; mif.mshr_hit = 1; mif.miss_paddr = 15'h0333;
        cycle();
        mif.miss_valid = 0; mif.mshr_hit = 0;
        cycle();

        // Stall while full, accept once full drops.
        mif.mshr_full = 1; mif.miss_valid = 1; mif.miss_paddr = 15'h2222; mif.miss_ptcid = 7'h03;
        repeat (4) cycle();
        mif.mshr_full = 0;
        cycle();
        mif.miss_valid = 0; mif.bus_req_ready = 1;
        cycle();
        mif.bus_req_ready = 0;

        // Fill and miss together: fill wins, miss goes in next cycle.
        mif.miss_valid = 1; mif.miss_paddr = 15'h0456; mif.miss_ptcid = 7'h05;
        mif.fill_valid = 1; mif.mshr_qslots = 8'hA0; mif.mshr_wake = 2'b01;
        cycle();
        mif.fill_valid = 0;
        cycle();
        mif.miss_valid = 0; mif.bus_req_ready = 1;
        cycle();
        mif.bus_req_ready = 0;
        mif.miss_valid = 1; mif.miss_paddr = 15'h0789; mif.miss_ptcid = 7'h42;
        cycle();
        mif.miss_valid = 0; mif.bus_req_ready = 1;
        cycle();
        mif.bus_req_ready = 0;

        // Back-to-back fills give consecutive wake pulses.
        mif.fill_valid = 1; mif.mshr_qslots = 8'h11; mif.mshr_wake = 2'b11;
        cycle();
        mif.mshr_qslots = 8'h22; mif.mshr_wake = 2'b01;
        cycle();
        mif.fill_valid = 0;
        cycle();

        // Fill with nothing issued: ignored, sticky error.
        mif.fill_valid = 1;
        cycle();
        mif.fill_valid = 0;
        cycle();
        cycle();
        chk("t6_err_sticky", mif.err, 1);

        // Fill the MSHR to DEPTH, overflow once, then reset mid-REQ.
        clr = 1;
        cycle();
        clr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mif.miss_valid = 1; mif.miss_paddr = PADDR_W'(16'h0100 + i); mif.miss_ptcid = TCID_W'(i);
            cycle();
            mif.miss_valid = 0; mif.bus_req_ready = 1;
            cycle();
            mif.bus_req_ready = 0;
        end
        chk("t7_full_count", mif.outstanding, DEPTH);
        mif.miss_valid = 1; mif.miss_paddr = 15'h7FFF;
        cycle();
        mif.miss_valid = 0;
        chk("t7_overflow_err", mif.err, 1);
        chk("t7_saturate", mif.outstanding, DEPTH);
        cycle();
        clr = 1;
        cycle();
        clr = 0;
        chk("t8_req_dropped", mif.bus_req_valid, 0);
        chk("t8_outstanding", mif.outstanding, 0);
        chk("t8_err_cleared", mif.err, 0);
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
